block_mover: RTL

BLOCK_MOVER -- requirements
Module: block_mover

---
 rtl/block_mover_if.sv | 32 +++
 rtl/block_mover.sv | 91 +++++++++
 2 files changed

// File: rtl/block_mover_if.sv
// block_mover_if: command/status, DRAM read and fabric write signals of the block mover.
interface block_mover_if;
   logic        BLCK_ISSUE;
   logic [11:0] BLCK_START;
   logic [5:0]  BLCK_COUNT_REQ;
   logic [1:0]  BLCK_SECTION;
   logic        BLCK_ABORT;
   logic [5:0]  BLCK_COUNT_SENT;
   logic        BLCK_WORKING;
   logic        BLCK_IRQ;
   logic        BLCK_ABRUPT_STOP;
   logic        BLCK_FRDRAM_DEVERR;
   logic        MEM_REQ;
   logic [11:0] MEM_ADDR;
   logic        MEM_ACK;
   logic        MEM_ERR;
   logic [15:0] MEM_RDATA;
   logic [15:0] FAB_DATA;
   logic [3:0]  FAB_WE;
   modport slave (
      input  BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, BLCK_ABORT,
      input  MEM_ACK, MEM_ERR, MEM_RDATA,
      output BLCK_COUNT_SENT, BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR,
      output MEM_REQ, MEM_ADDR, FAB_DATA, FAB_WE
   );
   modport master (
      output BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, BLCK_ABORT,
      output MEM_ACK, MEM_ERR, MEM_RDATA,
      input  BLCK_COUNT_SENT, BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR,
      input  MEM_REQ, MEM_ADDR, FAB_DATA, FAB_WE
   );
endinterface

// File: rtl/block_mover.sv
// block_mover: copies a block of DRAM words to one of four fabric ports per toggle-issued command.
module block_mover #(
   parameter int MAX_WAIT = 255
) (
   input logic CLK,
   input logic RST,
   block_mover_if.slave bus
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;
   state_t r_state, w_next;
   logic r_issue_seen, r_working, r_abrupt, r_deverr, r_mem_req;
   logic [5:0] r_count_req, r_count_sent, w_sent_inc;
   logic [1:0] r_section;
   logic [11:0] r_mem_addr;
   logic [15:0] r_fab_data;
   logic [3:0] r_fab_we;
   logic [WW-1:0] r_wait;
   logic w_accept, w_xfer, w_good, w_bad, w_timeout, w_last, w_abrupt;
   assign w_accept = r_state == IDLE && bus.BLCK_ISSUE != r_issue_seen;
   assign w_xfer = r_state == XFER;
   assign w_good = w_xfer && bus.MEM_ACK && !bus.MEM_ERR;
   assign w_bad = w_xfer && bus.MEM_ACK && bus.MEM_ERR;
   assign w_timeout = w_xfer && !bus.MEM_ACK && r_wait == WW'(MAX_WAIT - 1);
   assign w_sent_inc = r_count_sent + 6'd1;
   // 6-bit wrap lets a requested count of 0 complete on the 64th word
   assign w_last = w_good && w_sent_inc == r_count_req;
   assign w_abrupt = w_bad || w_timeout || (w_xfer && bus.BLCK_ABORT && !w_last);
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = XFER;
      else if (r_state == FINISH) w_next = IDLE;
      else if (w_last || w_abrupt) w_next = FINISH;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_issue_seen <= 1'b0;
         r_working <= 1'b0;
         r_abrupt <= 1'b0;
         r_deverr <= 1'b0;
         r_mem_req <= 1'b0;
         r_count_req <= '0;
         r_count_sent <= '0;
         r_section <= '0;
         r_mem_addr <= '0;
         r_fab_data <= '0;
         r_fab_we <= '0;
         r_wait <= '0;
      end else begin
         r_fab_we <= '0;
         if (w_accept) begin
            r_issue_seen <= bus.BLCK_ISSUE;
            r_count_req <= bus.BLCK_COUNT_REQ;
            r_section <= bus.BLCK_SECTION;
            r_mem_addr <= bus.BLCK_START;
            r_count_sent <= '0;
            r_abrupt <= 1'b0;
            r_deverr <= 1'b0;
            r_working <= 1'b1;
            r_mem_req <= 1'b1;
            r_wait <= '0;
         end
         if (w_xfer) begin
            r_wait <= bus.MEM_ACK ? '0 : r_wait + WW'(1);
            if (w_good) begin
               r_fab_data <= bus.MEM_RDATA;
               r_fab_we <= 4'b0001 << r_section;
               r_count_sent <= w_sent_inc;
               r_mem_addr <= r_mem_addr + 12'd1;
            end
            if (w_abrupt) r_abrupt <= 1'b1;
            if (w_bad || w_timeout) r_deverr <= 1'b1;
            if (w_last || w_abrupt) r_mem_req <= 1'b0;
         end
         if (r_state == FINISH) r_working <= 1'b0;
      end
   end
   assign bus.BLCK_COUNT_SENT = r_count_sent;
   assign bus.BLCK_WORKING = r_working;
   assign bus.BLCK_IRQ = r_state == FINISH;
   assign bus.BLCK_ABRUPT_STOP = r_abrupt;
   assign bus.BLCK_FRDRAM_DEVERR = r_deverr;
   assign bus.MEM_REQ = r_mem_req;
   assign bus.MEM_ADDR = r_mem_addr;
   assign bus.FAB_DATA = r_fab_data;
   assign bus.FAB_WE = r_fab_we;
endmodule
